// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states and the
// instruction field layout {opcode, rd, rs1, rs2, imm}, MSB first.
package core_pkg;

  localparam logic [2:0] OP_LOADI = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_MOV   = 3'b110;
  localparam logic [2:0] OP_ADDI  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_e;

  function automatic int instr_w(input int aw, input int dw);
    return 3 + 3 * aw + dw;
  endfunction

  function automatic int op_lsb(input int aw, input int dw);
    return 3 * aw + dw;
  endfunction

  function automatic int rd_lsb(input int aw, input int dw);
    return 2 * aw + dw;
  endfunction

  function automatic int rs1_lsb(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int rs2_lsb(input int aw, input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two registered read ports, one write port, sync clear of
// every entry, and a combinational debug read port.
module regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[wa] <= wd;
    end
  end

  // Read data is pure datapath: no reset needed, the FSM never consumes it stale.
  always_ff @(posedge clk) begin
    rd1_q <= regs_q[ra1];
    rd2_q <= regs_q[ra2];
  end

  assign rd1      = rd1_q;
  assign rd2      = rd2_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/multicycle_core.sv
// Four-state instruction processor: IDLE accepts, DECODE reads the register
// file, EXECUTE runs the ALU, WRITEBACK commits the result.
module multicycle_core
  import core_pkg::*;
#(
  parameter  int DATA_W  = 16,
  parameter  int ADDR_W  = 5,
  localparam int INSTR_W = instr_w(ADDR_W, DATA_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  result,
  output logic [ADDR_W-1:0]  result_addr,
  output logic               result_valid,
  output logic               zero_flag,
  output logic               carry_flag,
  input  logic [ADDR_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  localparam int OP_L  = op_lsb(ADDR_W, DATA_W);
  localparam int RD_L  = rd_lsb(ADDR_W, DATA_W);
  localparam int RS1_L = rs1_lsb(ADDR_W, DATA_W);
  localparam int RS2_L = rs2_lsb(ADDR_W, DATA_W);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  result_q;
  logic [ADDR_W-1:0]  result_addr_q;
  logic               zero_q;
  logic               carry_q;

  logic [2:0]         op;
  logic [ADDR_W-1:0]  rd_a, rs1_a, rs2_a;
  logic [DATA_W-1:0]  imm;
  logic [DATA_W-1:0]  rs1_data, rs2_data;
  logic [DATA_W:0]    sum_ext, diff_ext;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_carry, alu_sets_carry;
  logic               accept;

  assign op    = instr_q[OP_L +: 3];
  assign rd_a  = instr_q[RD_L +: ADDR_W];
  assign rs1_a = instr_q[RS1_L +: ADDR_W];
  assign rs2_a = instr_q[RS2_L +: ADDR_W];
  assign imm   = instr_q[DATA_W-1:0];

  assign instr_ready  = (state_q == S_IDLE);
  assign result_valid = (state_q == S_WRITEBACK);
  assign accept       = instr_valid && instr_ready;

  regfile_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .ra1      (rs1_a),
    .ra2      (rs2_a),
    .rd1      (rs1_data),
    .rd2      (rs2_data),
    .we       (state_q == S_WRITEBACK),
    .wa       (result_addr_q),
    .wd       (result_q),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (accept) state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // One adder serves ADD and ADDI; the subtractor's top bit is the borrow.
  always_comb begin
    sum_ext        = {1'b0, rs1_data} + {1'b0, (op == OP_ADDI) ? imm : rs2_data};
    diff_ext       = {1'b0, rs1_data} - {1'b0, rs2_data};
    alu_res        = '0;
    alu_carry      = 1'b0;
    alu_sets_carry = 1'b0;
    case (op)
      OP_LOADI: alu_res = imm;
      OP_ADD, OP_ADDI: begin
        alu_res        = sum_ext[DATA_W-1:0];
        alu_carry      = sum_ext[DATA_W];
        alu_sets_carry = 1'b1;
      end
      OP_SUB: begin
        alu_res        = diff_ext[DATA_W-1:0];
        alu_carry      = diff_ext[DATA_W];
        alu_sets_carry = 1'b1;
      end
      OP_AND:  alu_res = rs1_data & rs2_data;
      OP_OR:   alu_res = rs1_data | rs2_data;
      OP_XOR:  alu_res = rs1_data ^ rs2_data;
      OP_MOV:  alu_res = rs1_data;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) instr_q <= instr;
  end

  // Result and flags register at the end of EXECUTE so they are stable for WRITEBACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      result_q      <= '0;
      result_addr_q <= '0;
      zero_q        <= 1'b0;
      carry_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXECUTE) begin
        result_q      <= alu_res;
        result_addr_q <= rd_a;
        zero_q        <= (alu_res == '0);
        if (alu_sets_carry) carry_q <= alu_carry;
      end
    end
  end

  assign result      = result_q;
  assign result_addr = result_addr_q;
  assign zero_flag   = zero_q;
  assign carry_flag  = carry_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: a reference model pushes expected
// writebacks at issue time; each scenario pops and compares on result_valid.
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [33:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] result;
  logic [4:0]  result_addr;
  logic        result_valid;
  logic        zero_flag;
  logic        carry_flag;
  logic [4:0]  dbg_addr;
  logic [15:0] dbg_data;

  multicycle_core #(.DATA_W(16), .ADDR_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .result       (result),
    .result_addr  (result_addr),
    .result_valid (result_valid),
    .zero_flag    (zero_flag),
    .carry_flag   (carry_flag),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  addr;
    logic        z;
    logic        c;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mdl[32];
  logic        mdl_c;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [33:0] mk(input logic [2:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic push_exp(input logic [33:0] w);
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [15:0] a, b, imm, r;
    logic [16:0] s;
    exp_t        e;
    op  = w[33:31];
    rd  = w[30:26];
    a   = mdl[w[25:21]];
    b   = mdl[w[20:16]];
    imm = w[15:0];
    r   = 16'h0;
    case (op)
      3'd0: r = imm;
      3'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; mdl_c = s[16]; end
      3'd2: begin r = a - b; mdl_c = (a < b); end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = a;
      3'd7: begin s = {1'b0, a} + {1'b0, imm}; r = s[15:0]; mdl_c = s[16]; end
      default: r = 16'h0;
    endcase
    mdl[rd] = r;
    e.data = r; e.addr = rd; e.z = (r == 16'h0); e.c = mdl_c;
    sbq.push_back(e);
  endtask

  task automatic send(input logic [33:0] w);
    int n = 0;
    while (!instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!instr_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_ready_timeout instr_ready=%b required=1", instr_ready);
    end
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_result(output bit got);
    int n = 0;
    while (!result_valid && n < 10) begin @(posedge clk); #1; n++; end
    got = result_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 16'h0;
    mdl_c = 1'b0;
    n_cmp++;
    if ({instr_ready, result_valid, zero_flag, carry_flag, result, result_addr} !== {4'b1000, 16'h0, 5'h0}) begin
      n_err++;
      $display("FAIL reset_outputs rdy/vld/z/c=%b%b%b%b res=%h addr=%0d required 1000 0000 0",
               instr_ready, result_valid, zero_flag, carry_flag, result, result_addr);
    end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      n_cmp++;
      if (dbg_data !== 16'h0) begin
        n_err++;
        $display("FAIL reset_reg r%0d got=%h required=0000", i, dbg_data);
      end
    end
  endtask

  task automatic test_arith();
    logic [33:0] prog[3];
    exp_t e;
    bit got;
    prog[0] = mk(3'd0, 5'd1, 5'd0, 5'd0, 16'h1234);
    prog[1] = mk(3'd0, 5'd2, 5'd0, 5'd0, 16'h0001);
    prog[2] = mk(3'd1, 5'd3, 5'd1, 5'd2, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      push_exp(prog[i]);
      send(prog[i]);
      wait_result(got);
      e = sbq.pop_front();
      n_cmp++;
      if (!got) begin
        n_err++; $display("FAIL arith[%0d] result_valid timeout", i);
      end else if ({result, result_addr, zero_flag, carry_flag} !== {e.data, e.addr, e.z, e.c}) begin
        n_err++;
        $display("FAIL arith[%0d] got res=%h addr=%0d z=%b c=%b required res=%h addr=%0d z=%b c=%b",
                 i, result, result_addr, zero_flag, carry_flag, e.data, e.addr, e.z, e.c);
      end
    end
    n_cmp++;
    if ({result, result_addr, carry_flag, zero_flag} !== {16'h1235, 5'd3, 2'b00}) begin
      n_err++;
      $display("FAIL add_literal got res=%h addr=%0d c=%b z=%b required 1235 3 0 0",
               result, result_addr, carry_flag, zero_flag);
    end
  endtask

  task automatic test_flags();
    logic [33:0] prog[3];
    exp_t e;
    bit got;
    prog[0] = mk(3'd0, 5'd4, 5'd0, 5'd0, 16'hFFFF);
    prog[1] = mk(3'd7, 5'd5, 5'd4, 5'd0, 16'h0001);
    prog[2] = mk(3'd3, 5'd6, 5'd4, 5'd1, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      push_exp(prog[i]);
      send(prog[i]);
      wait_result(got);
      e = sbq.pop_front();
      n_cmp++;
      if (!got) begin
        n_err++; $display("FAIL flags[%0d] result_valid timeout", i);
      end else if ({result, result_addr, zero_flag, carry_flag} !== {e.data, e.addr, e.z, e.c}) begin
        n_err++;
        $display("FAIL flags[%0d] got res=%h addr=%0d z=%b c=%b required res=%h addr=%0d z=%b c=%b",
                 i, result, result_addr, zero_flag, carry_flag, e.data, e.addr, e.z, e.c);
      end
    end
    n_cmp++;
    if ({result, carry_flag, zero_flag} !== {16'h1234, 2'b10}) begin
      n_err++;
      $display("FAIL and_keeps_carry got res=%h c=%b z=%b required 1234 1 0", result, carry_flag, zero_flag);
    end
  endtask

  task automatic test_logic();
    logic [33:0] prog[6];
    exp_t e;
    bit got;
    prog[0] = mk(3'd2, 5'd7,  5'd0, 5'd2, 16'h0000);
    prog[1] = mk(3'd5, 5'd8,  5'd4, 5'd1, 16'h0000);
    prog[2] = mk(3'd6, 5'd9,  5'd8, 5'd0, 16'h0000);
    prog[3] = mk(3'd4, 5'd14, 5'd1, 5'd2, 16'h0000);
    prog[4] = mk(3'd1, 5'd15, 5'd4, 5'd4, 16'h0000);
    prog[5] = mk(3'd2, 5'd31, 5'd1, 5'd2, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      push_exp(prog[i]);
      send(prog[i]);
      wait_result(got);
      e = sbq.pop_front();
      n_cmp++;
      if (!got) begin
        n_err++; $display("FAIL logic[%0d] result_valid timeout", i);
      end else if ({result, result_addr, zero_flag, carry_flag} !== {e.data, e.addr, e.z, e.c}) begin
        n_err++;
        $display("FAIL logic[%0d] got res=%h addr=%0d z=%b c=%b required res=%h addr=%0d z=%b c=%b",
                 i, result, result_addr, zero_flag, carry_flag, e.data, e.addr, e.z, e.c);
      end
    end
    dbg_addr = 5'd9; #1;
    n_cmp++;
    if (dbg_data !== 16'hEDCB) begin
      n_err++; $display("FAIL mov_literal r9 got=%h required=edcb", dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] prog[4];
    exp_t e;
    bit got;
    prog[0] = mk(3'd7, 5'd13, 5'd13, 5'd0, 16'h0001);
    prog[1] = mk(3'd7, 5'd13, 5'd13, 5'd0, 16'h0001);
    prog[2] = mk(3'd1, 5'd13, 5'd13, 5'd13, 16'h0000);
    prog[3] = mk(3'd2, 5'd13, 5'd13, 5'd13, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      push_exp(prog[i]);
      send(prog[i]);
      wait_result(got);
      e = sbq.pop_front();
      n_cmp++;
      if (!got) begin
        n_err++; $display("FAIL b2b[%0d] result_valid timeout", i);
      end else if ({result, result_addr, zero_flag, carry_flag} !== {e.data, e.addr, e.z, e.c}) begin
        n_err++;
        $display("FAIL b2b[%0d] got res=%h addr=%0d z=%b c=%b required res=%h addr=%0d z=%b c=%b",
                 i, result, result_addr, zero_flag, carry_flag, e.data, e.addr, e.z, e.c);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      n_cmp++;
      if (dbg_data !== mdl[i]) begin
        n_err++; $display("FAIL regdump r%0d got=%h required=%h", i, dbg_data, mdl[i]);
      end
    end
  endtask

  task automatic test_hold_valid();
    exp_t e;
    int   pulses = 0;
    int   last_c = 0;
    int   n = 0;
    while (!instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 14; c++) begin
      if (result_valid) begin
        pulses++;
        n_cmp++;
        if (sbq.size() == 0) begin
          n_err++; $display("FAIL hold_extra_pulse cycle=%0d res=%h required no pulse", c, result);
        end else begin
          e = sbq.pop_front();
          if ({result, result_addr, zero_flag, carry_flag} !== {e.data, e.addr, e.z, e.c}) begin
            n_err++;
            $display("FAIL hold_result got res=%h addr=%0d z=%b c=%b required res=%h addr=%0d z=%b c=%b",
                     result, result_addr, zero_flag, carry_flag, e.data, e.addr, e.z, e.c);
          end
        end
        if (pulses == 2) begin
          n_cmp++;
          if (c - last_c !== 4) begin
            n_err++; $display("FAIL hold_spacing got=%0d required=4", c - last_c);
          end
        end
        last_c = c;
      end
      if (c < 8) begin
        instr = mk(3'd0, 5'd12, 5'd0, 5'd0, 16'h1000 + 16'(c));
        instr_valid = 1'b1;
        if (c % 4 == 0) push_exp(instr);
      end else begin
        instr_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (pulses !== 2) begin
      n_err++; $display("FAIL hold_pulse_count got=%0d required=2", pulses);
    end
    dbg_addr = 5'd12; #1;
    n_cmp++;
    if (dbg_data !== 16'h1004) begin
      n_err++; $display("FAIL hold_r12 got=%h required=1004", dbg_data);
    end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    send(mk(3'd0, 5'd10, 5'd0, 5'd0, 16'hBEEF));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 16'h0;
    mdl_c = 1'b0;
    n_cmp++;
    if ({instr_ready, result_valid, zero_flag, carry_flag} !== 4'b1000) begin
      n_err++;
      $display("FAIL abort_state rdy/vld/z/c got=%b%b%b%b required=1000",
               instr_ready, result_valid, zero_flag, carry_flag);
    end
    for (int c = 0; c < 6; c++) begin
      if (result_valid) pulses++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++; $display("FAIL abort_pulses got=%0d required=0", pulses);
    end
    dbg_addr = 5'd10; #1;
    n_cmp++;
    if (dbg_data !== 16'h0) begin
      n_err++; $display("FAIL abort_r10 got=%h required=0000", dbg_data);
    end
    dbg_addr = 5'd1; #1;
    n_cmp++;
    if (dbg_data !== 16'h0) begin
      n_err++; $display("FAIL abort_r1 got=%h required=0000", dbg_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    dbg_addr    = '0;
    mdl_c       = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 16'h0;
    @(posedge clk); #1;
    test_reset();
    test_arith();
    test_flags();
    test_logic();
    test_back_to_back();
    test_hold_valid();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
